// File: rtl/int_dot_product_acc.sv
// int_dot_product_acc: pipelined integer dot product with a registered adder tree and multi-beat accumulation.
// Define DOT_SIGNED_EN for two's-complement operands and signed-overflow reporting on out_ovf.

module int_dot_product_acc_lane #(
    parameter int DWIDTH = 4
) (
    input  logic [DWIDTH-1:0]   a_i,
    input  logic [DWIDTH-1:0]   b_i,
    output logic [2*DWIDTH-1:0] p_o
);
    logic [2*DWIDTH-1:0] a_x, b_x;

`ifdef DOT_SIGNED_EN
    assign a_x = {{DWIDTH{a_i[DWIDTH-1]}}, a_i};
    assign b_x = {{DWIDTH{b_i[DWIDTH-1]}}, b_i};
`else
    assign a_x = {{DWIDTH{1'b0}}, a_i};
    assign b_x = {{DWIDTH{1'b0}}, b_i};
`endif

    // Low 2*DWIDTH bits of the product of extended operands are exact in both modes.
    assign p_o = a_x * b_x;
endmodule

module int_dot_product_acc #(
    parameter int DWIDTH    = 4,
    parameter int NUM_PAIRS = 4,
    parameter int ACC_WIDTH = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          in_valid,
    input  logic                          in_last,
    input  logic [2*NUM_PAIRS*DWIDTH-1:0] inp,
    output logic                          out_valid,
    output logic [ACC_WIDTH-1:0]          out,
    output logic [CNT_WIDTH-1:0]          out_count,
    output logic                          out_ovf
);
    localparam int T      = $clog2(NUM_PAIRS);
    localparam int PW     = 2 * DWIDTH;
    localparam int SW     = PW + T;
    localparam int STAGES = T + 1;

    typedef enum logic {IDLE, ACC} state_t;

    logic [2*NUM_PAIRS*DWIDTH-1:0]  inp_q;
    logic [STAGES:0]                vld_pipe_q, last_pipe_q;
    logic [NUM_PAIRS-1:0][PW-1:0]   prod;
    logic [NUM_PAIRS-1:0][SW-1:0]   prod_x;
    // Heap-ordered tree: leaves at NUM_PAIRS..2*NUM_PAIRS-1, node j sums 2j and 2j+1, root is 1.
    logic [2*NUM_PAIRS-1:1][SW-1:0] tree_q;
    logic [ACC_WIDTH-1:0]           sum_ext;

    state_t                state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d, acc_base, acc_sum, out_q, out_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_base, cnt_inc, cnt_out_q, cnt_out_d;
    logic                  ovf_q, ovf_d, ovf_base, ovf_out_q, ovf_out_d;
    logic                  out_valid_q, out_valid_d;
    logic                  carry, wrap, sum_vld, sum_last;

    genvar k;
    generate
        for (k = 0; k < NUM_PAIRS; k++) begin : g_lane
            int_dot_product_acc_lane #(.DWIDTH(DWIDTH)) u_lane (
                .a_i (inp_q[(2*k+1)*DWIDTH +: DWIDTH]),
                .b_i (inp_q[2*k*DWIDTH +: DWIDTH]),
                .p_o (prod[k])
            );
`ifdef DOT_SIGNED_EN
            assign prod_x[k] = {{T{prod[k][PW-1]}}, prod[k]};
`else
            assign prod_x[k] = {{T{1'b0}}, prod[k]};
`endif
        end

        if (ACC_WIDTH > SW) begin : g_ext
`ifdef DOT_SIGNED_EN
            assign sum_ext = {{(ACC_WIDTH-SW){tree_q[1][SW-1]}}, tree_q[1]};
`else
            assign sum_ext = {{(ACC_WIDTH-SW){1'b0}}, tree_q[1]};
`endif
        end else begin : g_noext
            assign sum_ext = tree_q[1];
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inp_q       <= '0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            tree_q      <= '0;
        end else begin
            inp_q       <= inp;
            vld_pipe_q  <= {vld_pipe_q[STAGES-1:0], in_valid};
            last_pipe_q <= {last_pipe_q[STAGES-1:0], in_valid & in_last};
            for (int i = 0; i < NUM_PAIRS; i++) tree_q[NUM_PAIRS+i] <= prod_x[i];
            for (int j = 1; j < NUM_PAIRS; j++) tree_q[j] <= tree_q[2*j] + tree_q[2*j+1];
        end
    end

    assign sum_vld  = vld_pipe_q[STAGES];
    assign sum_last = last_pipe_q[STAGES];

    always_comb begin
        // A vector starting from IDLE sees a zero accumulator, count and flag.
        acc_base = (state_q == ACC) ? acc_q : '0;
        cnt_base = (state_q == ACC) ? cnt_q : '0;
        ovf_base = (state_q == ACC) ? ovf_q : 1'b0;
        {carry, acc_sum} = {1'b0, acc_base} + {1'b0, sum_ext};
`ifdef DOT_SIGNED_EN
        wrap = (acc_base[ACC_WIDTH-1] == sum_ext[ACC_WIDTH-1]) &&
               (acc_sum[ACC_WIDTH-1] != acc_base[ACC_WIDTH-1]);
`else
        wrap = carry;
`endif
        cnt_inc = (&cnt_base) ? cnt_base : cnt_base + CNT_WIDTH'(1);

        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_d       = out_q;
        cnt_out_d   = cnt_out_q;
        ovf_out_d   = ovf_out_q;
        out_valid_d = 1'b0;
        if (sum_vld) begin
            if (sum_last) begin
                state_d     = IDLE;
                out_valid_d = 1'b1;
                out_d       = acc_sum;
                cnt_out_d   = cnt_inc;
                ovf_out_d   = ovf_base | wrap;
            end else begin
                state_d = ACC;
                acc_d   = acc_sum;
                cnt_d   = cnt_inc;
                ovf_d   = ovf_base | wrap;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_q       <= '0;
            cnt_out_q   <= '0;
            ovf_out_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_q       <= out_d;
            cnt_out_q   <= cnt_out_d;
            ovf_out_q   <= ovf_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign out_count = cnt_out_q;
    assign out_ovf   = ovf_out_q;
endmodule
